// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with single-cycle ops plus multi-cycle shift-add MULU and restoring DIVU
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             qc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             carry,
  output logic             overflow,
  output logic             negative,
  output logic             zero
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t r_state, w_state_n;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_b, r_y, r_yh;
  logic r_mul, r_c, r_v, r_n, r_z;
  logic w_accept, w_mul, w_div, w_last, w_ge;
  logic [WIDTH-1:0] w_bp, w_y, w_yh, w_hi_n, w_lo_n, w_dd;
  logic [WIDTH:0] w_sum, w_msum, w_dt;
  logic w_c, w_v;
  assign w_accept = start && r_state != RUN;
  assign w_mul    = op == 5'h10;
  assign w_div    = op == 5'h11;
  assign w_last   = r_cnt == CNT_W'(WIDTH - 1);
  assign busy     = r_state == RUN;
  assign done     = r_state == FIN;
  assign y        = r_y;
  assign y_hi     = r_yh;
  assign carry    = r_c;
  assign overflow = r_v;
  assign negative = r_n;
  assign zero     = r_z;
  always_comb begin
    w_state_n = r_state == RUN ? (w_last ? FIN : RUN)
              : w_accept ? ((w_mul || (w_div && |b)) ? RUN : FIN)
              : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_n;
  end
  always_comb begin
    w_bp = op == 5'h01 ? WIDTH'(1)
         : op == 5'h03 ? b + WIDTH'(qc)
         : op == 5'h04 ? ~b + WIDTH'(qc)
         : op == 5'h05 ? ~b + WIDTH'(1)
         : op == 5'h06 ? {WIDTH{1'b1}}
         : b;
    w_sum = {1'b0, a} + {1'b0, w_bp};
    w_y   = '0;
    w_yh  = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (op)
      5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06: begin
        w_y = w_sum[WIDTH-1:0];
        w_c = w_sum[WIDTH];
        w_v = a[WIDTH-1] ^ w_bp[WIDTH-1] ^ w_sum[WIDTH-1] ^ w_sum[WIDTH];
      end
      5'h00, 5'h07: w_y = a;
      5'h08: w_y = a & b;
      5'h09: w_y = a | b;
      5'h0A: w_y = a ^ b;
      5'h0B: w_y = ~a;
      5'h0C: w_y = b;
      5'h0D: begin
        w_y = {1'b0, b[WIDTH-1:1]};
        w_c = b[0];
      end
      5'h0E: begin
        w_y = {b[WIDTH-2:0], 1'b0};
        w_c = b[WIDTH-1];
      end
      // only reachable as a single-cycle op when dividing by zero
      5'h11: begin
        w_y  = {WIDTH{1'b1}};
        w_yh = a;
        w_v  = 1'b1;
      end
      default: w_y = '0;
    endcase
  end
  // r_hi/r_lo hold partial product (MUL) or remainder/shifting dividend-quotient (DIV)
  always_comb begin
    w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_dt   = {r_hi, r_lo[WIDTH-1]};
    w_ge   = w_dt >= {1'b0, r_b};
    w_dd   = w_dt[WIDTH-1:0] - r_b;
    w_hi_n = r_mul ? w_msum[WIDTH:1] : (w_ge ? w_dd : w_dt[WIDTH-1:0]);
    w_lo_n = r_mul ? {w_msum[0], r_lo[WIDTH-1:1]} : {r_lo[WIDTH-2:0], w_ge};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_y  <= '0;
      r_yh <= '0;
      r_c  <= 1'b0;
      r_v  <= 1'b0;
      r_n  <= 1'b0;
      r_z  <= 1'b1;
    end else if (r_state == RUN) begin
      r_hi  <= w_hi_n;
      r_lo  <= w_lo_n;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_y  <= w_lo_n;
        r_yh <= w_hi_n;
        r_c  <= r_mul && |w_hi_n;
        r_v  <= r_mul && |w_hi_n;
        r_n  <= r_mul ? w_hi_n[WIDTH-1] : w_lo_n[WIDTH-1];
        r_z  <= r_mul ? ~|{w_hi_n, w_lo_n} : ~|w_lo_n;
      end
    end else if (w_accept) begin
      if (w_state_n == RUN) begin
        r_mul <= w_mul;
        r_b   <= b;
        r_hi  <= '0;
        r_lo  <= a;
        r_cnt <= '0;
      end else begin
        r_y  <= w_y;
        r_yh <= w_yh;
        r_c  <= w_c;
        r_v  <= w_v;
        r_n  <= w_y[WIDTH-1];
        r_z  <= ~|w_y;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed table-driven bench for alu_seq (WIDTH=16) with a WIDTH=8 spot-check instance
module tb_alu_seq;
  logic clk = 0, reset = 1, start = 0, qc = 0;
  logic [4:0] op = '0;
  logic [15:0] a = '0, b = '0;
  logic busy, done, carry, overflow, negative, zero;
  logic [15:0] y, y_hi;
  logic start8 = 0;
  logic [4:0] op8 = '0;
  logic [7:0] a8 = '0, b8 = '0, y8, yh8;
  logic busy8, done8, c8, v8, n8, z8;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .qc(qc),
    .busy(busy), .done(done), .y(y), .y_hi(y_hi), .carry(carry),
    .overflow(overflow), .negative(negative), .zero(zero));

  alu_seq #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8), .qc(qc),
    .busy(busy8), .done(done8), .y(y8), .y_hi(yh8), .carry(c8),
    .overflow(v8), .negative(n8), .zero(z8));

  typedef struct packed {
    logic [4:0] op; logic [15:0] a, b; logic qc;
    logic [15:0] y, yh; logic c, v, n, z;
  } vec_t;
  vec_t vecs [20];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic flags(input string nm, input logic [15:0] ey, eyh, input logic ec, ev, en, ez);
    chk({nm, ".y"}, 64'(y), 64'(ey));
    chk({nm, ".y_hi"}, 64'(y_hi), 64'(eyh));
    chk({nm, ".flags"}, 64'({carry, overflow, negative, zero}), 64'({ec, ev, en, ez}));
  endtask

  task automatic issue(input logic [4:0] o, input logic [15:0] x, input logic [15:0] z, input logic c);
    @(negedge clk);
    op = o; a = x; b = z; qc = c; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic run_multi(input logic [4:0] o, input logic [15:0] x, input logic [15:0] z,
                           input bit interfere, output int nb);
    int guard = 0;
    issue(o, x, z, 0);
    nb = 0;
    if (interfere) begin start = 1; op = 5'h02; a = 16'h1111; b = 16'h2222; end
    while (!done && guard < 100) begin
      guard++;
      nb += int'(busy);
      if (guard == 8) start = 0;
      @(posedge clk); #1;
    end
    start = 0;
  endtask

  task automatic run8(input logic [4:0] o, input logic [7:0] x, input logic [7:0] z, output int nb);
    int guard = 0;
    @(negedge clk);
    op8 = o; a8 = x; b8 = z; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    nb = 0;
    while (!done8 && guard < 100) begin
      guard++;
      nb += int'(busy8);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int nb, nd;
    vecs = '{
      '{5'h02, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0},
      '{5'h04, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0},
      '{5'h05, 16'h0005, 16'h0005, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1},
      '{5'h01, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1},
      '{5'h06, 16'h0000, 16'h1234, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0},
      '{5'h03, 16'h1000, 16'h0FFF, 1'b1, 16'h2000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0},
      '{5'h04, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0},
      '{5'h08, 16'hF0F0, 16'hFF00, 1'b0, 16'hF000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0},
      '{5'h09, 16'h00F0, 16'h0F00, 1'b0, 16'h0FF0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0},
      '{5'h0A, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1},
      '{5'h0B, 16'h00FF, 16'h0000, 1'b0, 16'hFF00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0},
      '{5'h0C, 16'h5555, 16'h1234, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0},
      '{5'h00, 16'hABCD, 16'h0000, 1'b0, 16'hABCD, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0},
      '{5'h07, 16'h0001, 16'hFFFF, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0},
      '{5'h0E, 16'h0000, 16'h8001, 1'b0, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0},
      '{5'h0D, 16'h0000, 16'h8001, 1'b0, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0},
      '{5'h0F, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1},
      '{5'h1F, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1},
      '{5'h11, 16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b0},
      '{5'h02, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1}
    };
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy_done", 64'({busy, done}), 64'(2'b00));
    flags("rst", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst8", 64'({busy8, done8, y8, yh8, c8, v8, n8, z8}), 64'({2'b00, 16'h0000, 4'b0001}));
    @(negedge clk);
    reset = 0;

    // back-to-back single-cycle ops: each issue lands in the previous op's done cycle
    for (int i = 0; i < 20; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].qc);
      chk($sformatf("v%0d.busy_done", i), 64'({busy, done}), 64'(2'b01));
      flags($sformatf("v%0d", i), vecs[i].y, vecs[i].yh, vecs[i].c, vecs[i].v, vecs[i].n, vecs[i].z);
    end

    issue(5'h02, 16'h7FFF, 16'h0001, 0);
    chk("pulse.done1", 64'(done), 64'(1));
    @(posedge clk); #1;
    chk("pulse.done0", 64'(done), 64'(0));
    chk("pulse.hold", 64'({y, overflow}), 64'({16'h8000, 1'b1}));

    run_multi(5'h10, 16'hFFFF, 16'hFFFF, 1, nb);
    chk("mul.busy_cycles", 64'(nb), 64'(16));
    chk("mul.busy_done", 64'({busy, done}), 64'(2'b01));
    flags("mul", 16'h0001, 16'hFFFE, 1'b1, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("mul.done_drop", 64'({busy, done}), 64'(2'b00));

    run_multi(5'h11, 16'd100, 16'd7, 0, nb);
    chk("div.busy_cycles", 64'(nb), 64'(16));
    flags("div", 16'd14, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0);

    issue(5'h10, 16'h0003, 16'h0005, 0);
    repeat (7) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1;
    chk("abort.busy_done", 64'({busy, done}), 64'(2'b00));
    flags("abort", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 0;
    nd = 0;
    repeat (20) begin @(posedge clk); #1; nd += int'(done); end
    chk("abort.no_done", 64'(nd), 64'(0));

    run_multi(5'h10, 16'h0000, 16'h1234, 0, nb);
    flags("mul0", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    run_multi(5'h10, 16'h1234, 16'h0010, 0, nb);
    flags("mulsmall", 16'h2340, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0);
    run_multi(5'h11, 16'hFFFF, 16'h0001, 0, nb);
    flags("divone", 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);

    run8(5'h02, 8'h7F, 8'h01, nb);
    chk("w8.add", 64'({y8, c8, v8, n8, z8}), 64'({8'h80, 4'b0110}));
    run8(5'h10, 8'hFF, 8'hFF, nb);
    chk("w8.mul_busy", 64'(nb), 64'(8));
    chk("w8.mul", 64'({y8, yh8, c8, v8, n8, z8}), 64'({8'h01, 8'hFE, 4'b1110}));
    run8(5'h11, 8'd100, 8'd7, nb);
    chk("w8.div", 64'({y8, yh8, c8, v8, n8, z8}), 64'({8'd14, 8'd2, 4'b0000}));
    run8(5'h11, 8'h5A, 8'h00, nb);
    chk("w8.div0_lat", 64'(nb), 64'(0));
    chk("w8.div0", 64'({y8, yh8, c8, v8, n8, z8}), 64'({8'hFF, 8'h5A, 4'b0110}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
